lsu_mem_access: RTL and testbench
=================================

Name: lsu_mem_access

Overview:
Memory-access stage that consumes the execute stage's ALU result as the effective address and rs2 data as store data. It performs RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) over a req/ack data-memory interface. It handles byte-lane alignment, store data replication, load sign/zero extension, misalignment and illegal-funct3 detection, and a bus timeout. It holds busy so the control path stalls until done.

Parameters:
TIMEOUT_CYCLES, 64, cycles without dmem_ack after the request before the transaction aborts with err_bus (range 1..255).

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  one-cycle request from control; sampled only in IDLE
mem_read  input  1  load operation
mem_write  input  1  store operation
funct3  input  3  RV32I load/store width code
alu_result  input  32  effective byte address from execute stage
rs2_data  input  32  store source data
busy  output  1  high from cycle after accepted start until cycle after done
done  output  1  one-cycle completion pulse (success or any error)
load_data  output  32  formatted load result, valid when done and mem_read op succeeded
err_misaligned  output  1  pulses with done: address not aligned to access width
err_illegal  output  1  pulses with done: funct3 invalid for the operation
err_bus  output  1  pulses with done: timeout expired
dmem_req  output  1  memory request, held until ack
dmem_we  output  1  1 = write
dmem_addr  output  32  word address (alu_result with [1:0] forced to 0)
dmem_wdata  output  32  replicated store data
dmem_be  output  4  byte enables
dmem_ack  input  1  memory acknowledge, one cycle
dmem_rdata  input  32  read data, valid with dmem_ack

Behaviour:
- Reset: state IDLE; all outputs 0, load_data 0, timeout counter 0. Async assertion drops dmem_req immediately, including mid-transaction. Acks arriving after reset are ignored.
- Accepted start: start=1 in IDLE with exactly one of mem_read/mem_write set. Start with both or neither set is ignored, with no response. Start outside IDLE is ignored.
- FSM states: IDLE, REQ, FAULT, DONE.
  - IDLE -> FAULT on accepted start with a misaligned address or illegal funct3.
  - IDLE -> REQ otherwise. Address, we, be and wdata are registered; dmem_req=1 from the next cycle.
  - REQ holds req/addr/we/be/wdata stable every cycle until ack.
  - REQ + dmem_ack -> DONE: load_data latched from dmem_rdata, req deasserted in the same edge.
  - REQ with counter reaching TIMEOUT_CYCLES and no ack -> DONE with err_bus=1, req deasserted. An ack in the same cycle as expiry wins: success.
  - FAULT -> DONE: no memory request issued.
  - DONE: done=1 for one cycle, error flags valid, then -> IDLE. busy falls with the IDLE transition.
- Latency:
  - Start at cycle T gives req at T+1.
  - Ack at T+k (k>=1) gives done at T+k+1.
  - Minimum successful latency is 2 cycles.
  - Fault latency is 2 cycles.
- Alignment and validity:
  - Halfword needs addr[0]=0; word needs addr[1:0]=0.
  - Valid load funct3: 000,001,010,100,101. Valid store funct3: 000,001,010.
  - Illegal takes priority over misaligned.
- Stores:
  - SB: be=1<<addr[1:0], wdata={4{rs2[7:0]}}.
  - SH: be=addr[1]?1100:0011, wdata={2{rs2[15:0]}}.
  - SW: be=1111, wdata=rs2.
- Loads: be=1111. Byte/halfword selected by addr[1:0], sign-extended (000,001) or zero-extended (100,101). LW passes dmem_rdata through.
- load_data holds its last value until the next successful load; it is 0 after reset. It is unchanged on stores and errors.
- dmem_ack while in IDLE/FAULT/DONE is ignored.

Decomposition:
- Package lsu_pkg:
  - state enum {IDLE, REQ, FAULT, DONE}.
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - Function computing byte enables from width and addr[1:0].
- Sub-module lsu_load_align: combinational extraction of the byte/halfword from dmem_rdata using offset and funct3, with sign/zero extension. It is instantiated once, feeding the load_data register.

Test Plan:
- SW addr 0x100, rs2 0xDEADBEEF, ack 3 cycles after req -> dmem_addr 0x100, be 1111, wdata 0xDEADBEEF, req held 3 cycles, done at T+4, no errors.
- LB addr 0x203, rdata 0x80FF_0000 -> load_data 0xFFFFFF80. Repeat with LBU -> 0x00000080. LHU addr 0x202 -> 0x000080FF.
- SH addr 0x102 rs2 0x1234ABCD -> be 1100, wdata 0xABCDABCD. SB addr 0x101 -> be 0010, wdata 0xCDCDCDCD.
- LW addr 0x102 -> no dmem_req ever, done+err_misaligned at T+2. Store with funct3 100 -> err_illegal only.
- No ack with TIMEOUT_CYCLES=4 -> req high 4 cycles, then done+err_bus, req low. Late ack afterwards ignored; load_data unchanged.
- rst_n low while in REQ -> dmem_req drops asynchronously, busy 0. Ack after release produces no done. A new start then completes normally.

Source files
------------

// File: rtl/lsu_mem_access_pkg.sv
// Shared types and helpers for the RV32I load/store memory-access stage.
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      FAULT = 2'd2,
      DONE  = 2'd3
   } lsu_state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // width is funct3[1:0]: 00 byte, 01 halfword, otherwise word
   function automatic logic [3:0] byte_enables(input logic [1:0] width, input logic [1:0] off);
      case (width)
         2'b00:   return 4'b0001 << off;
         2'b01:   return off[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/lsu_mem_access_if.sv
// Data-memory request/acknowledge bus between the LSU and memory.
interface lsu_mem_access_if;
   // req rises with a transaction and stays high, with we/addr/be/wdata stable,
   // until the single-cycle ack; rdata is valid only in the ack cycle.
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  be;
   logic        ack;
   logic [31:0] rdata;

   modport master (output req, we, addr, wdata, be, input ack, rdata);
   modport slave  (input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/lsu_mem_access_load_align.sv
// Selects the addressed byte/halfword of a read word and sign/zero extends it.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  off_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] data_o
);

   logic [31:0] shifted;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      shifted  = rdata_i >> {off_i, 3'b000};
      byte_sel = shifted[7:0];
      half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      case (funct3_i)
         F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
         F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
         F3_BU:   data_o = {24'h0, byte_sel};
         F3_HU:   data_o = {16'h0, half_sel};
         default: data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/lsu_mem_access.sv
// Memory-access stage: RV32I loads/stores over a req/ack bus with fault and timeout handling.
module lsu_mem_access
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  funct3,
   input  logic [31:0] alu_result,
   input  logic [31:0] rs2_data,
   output logic        busy,
   output logic        done,
   output logic [31:0] load_data,
   output logic        err_misaligned,
   output logic        err_illegal,
   output logic        err_bus,
   lsu_mem_access_if.master dmem,
   output lsu_state_e  state_dbg_o
);

   lsu_state_e  state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  off_q, off_d;
   logic [2:0]  f3_q, f3_d;
   logic        we_q, we_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        mis_q, mis_d, ill_q, ill_d, bus_q, bus_d;
   logic [31:0] load_q, load_d;
   logic [31:0] align_data;
   logic        accept, illegal, misal;

   lsu_load_align u_align (
      .rdata_i  (dmem.rdata),
      .off_i    (off_q),
      .funct3_i (f3_q),
      .data_o   (align_data)
   );

   always_comb begin
      accept = start && (mem_read ^ mem_write);
      if (mem_read) illegal = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
      else          illegal = !(funct3 inside {F3_B, F3_H, F3_W});
      case (funct3[1:0])
         2'b01:   misal = alu_result[0];
         2'b10:   misal = |alu_result[1:0];
         default: misal = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      off_d   = off_q;
      f3_d    = f3_q;
      we_d    = we_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      cnt_d   = cnt_q;
      mis_d   = mis_q;
      ill_d   = ill_q;
      bus_d   = bus_q;
      load_d  = load_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               ill_d   = illegal;
               mis_d   = !illegal && misal;
               bus_d   = 1'b0;
               cnt_d   = '0;
               addr_d  = {alu_result[31:2], 2'b00};
               off_d   = alu_result[1:0];
               f3_d    = funct3;
               we_d    = mem_write;
               be_d    = mem_write ? byte_enables(funct3[1:0], alu_result[1:0]) : 4'b1111;
               case (funct3[1:0])
                  2'b00:   wdata_d = {4{rs2_data[7:0]}};
                  2'b01:   wdata_d = {2{rs2_data[15:0]}};
                  default: wdata_d = rs2_data;
               endcase
               if (!mem_write) wdata_d = '0;
               state_d = (illegal || misal) ? FAULT : REQ;
            end
         end
         REQ: begin
            // An ack in the expiry cycle still counts as success.
            if (dmem.ack) begin
               state_d = DONE;
               if (!we_q) load_d = align_data;
            end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
               state_d = DONE;
               bus_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         FAULT:   state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         off_q   <= '0;
         f3_q    <= '0;
         we_q    <= 1'b0;
         be_q    <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
         mis_q   <= 1'b0;
         ill_q   <= 1'b0;
         bus_q   <= 1'b0;
         load_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         off_q   <= off_d;
         f3_q    <= f3_d;
         we_q    <= we_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
         mis_q   <= mis_d;
         ill_q   <= ill_d;
         bus_q   <= bus_d;
         load_q  <= load_d;
      end
   end

   // Bus fields are zero outside REQ so a reset mid-transaction clears them at once.
   always_comb begin
      busy           = (state_q != IDLE);
      done           = (state_q == DONE);
      err_misaligned = done && mis_q;
      err_illegal    = done && ill_q;
      err_bus        = done && bus_q;
      load_data      = load_q;
      dmem.req       = (state_q == REQ);
      dmem.we        = dmem.req && we_q;
      dmem.addr      = dmem.req ? addr_q : '0;
      dmem.be        = dmem.req ? be_q : '0;
      dmem.wdata     = dmem.req ? wdata_q : '0;
      state_dbg_o    = state_q;
   end

endmodule

// File: tb/tb_lsu_mem_access.sv
// Directed and randomized bench for lsu_mem_access with a behavioural load/store model.
module tb_lsu_mem_access;
   import lsu_pkg::*;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        mem_read = 1'b0;
   logic        mem_write = 1'b0;
   logic [2:0]  funct3 = '0;
   logic [31:0] alu_result = '0;
   logic [31:0] rs2_data = '0;
   logic        busy, done, err_misaligned, err_illegal, err_bus;
   logic [31:0] load_data;
   lsu_state_e  state_dbg;

   lsu_mem_access_if dmem ();

   int          total = 0;
   int          bad = 0;
   logic [31:0] exp_load = '0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   lsu_mem_access #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .mem_read       (mem_read),
      .mem_write      (mem_write),
      .funct3         (funct3),
      .alu_result     (alu_result),
      .rs2_data       (rs2_data),
      .busy           (busy),
      .done           (done),
      .load_data      (load_data),
      .err_misaligned (err_misaligned),
      .err_illegal    (err_illegal),
      .err_bus        (err_bus),
      .dmem           (dmem.master),
      .state_dbg_o    (state_dbg)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: plain arithmetic from the RV32I load/store rules.
   function automatic int size_of(input logic [2:0] f3);
      if (f3[1:0] == 2'b00) return 1;
      if (f3[1:0] == 2'b01) return 2;
      return 4;
   endfunction

   function automatic bit is_illegal(input bit rd, input logic [2:0] f3);
      if (rd) return !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
      return f3 > 2;
   endfunction

   function automatic logic [3:0] model_be(input bit rd, input logic [2:0] f3, input logic [31:0] addr);
      logic [3:0] be;
      int off = int'(addr % 4);
      int sz = size_of(f3);
      if (rd) return 4'hF;
      for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + sz);
      return be;
   endfunction

   function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] rs2);
      if (size_of(f3) == 1) return (rs2 & 32'hFF) * 32'h0101_0101;
      if (size_of(f3) == 2) return (rs2 & 32'hFFFF) * 32'h0001_0001;
      return rs2;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata);
      int sz = size_of(f3);
      logic [31:0] v, mask;
      if (sz == 4) return rdata;
      v = rdata >> (8 * (addr % 4));
      mask = (32'd1 << (8 * sz)) - 32'd1;
      v = v & mask;
      if (f3 < 4 && v[8*sz-1]) v = v | ~mask;
      return v;
   endfunction

   // ack_at: REQ cycle (1..TMO) in which memory acknowledges; anything else means never.
   task automatic run_op(input bit rd, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rs2, input int ack_at, input logic [31:0] rdata,
                         input string tag);
      bit ill, mis, ok;
      ill = is_illegal(rd, f3);
      mis = !ill && ((addr % size_of(f3)) != 0);
      ok  = (ack_at >= 1) && (ack_at <= TMO);
      start = 1'b1; mem_read = rd; mem_write = !rd; funct3 = f3;
      alu_result = addr; rs2_data = rs2;
      tick();
      start = 1'b0; alu_result = $urandom(); rs2_data = $urandom();
      if (ill || mis) begin
         check({tag, " fault_req"}, 32'(dmem.req), 32'd0);
         check({tag, " fault_busy"}, 32'(busy), 32'd1);
         tick();
         check({tag, " done"}, 32'(done), 32'd1);
         check({tag, " err_ill"}, 32'(err_illegal), 32'(ill));
         check({tag, " err_mis"}, 32'(err_misaligned), 32'(mis));
         check({tag, " err_bus"}, 32'(err_bus), 32'd0);
         check({tag, " req"}, 32'(dmem.req), 32'd0);
         check({tag, " load_data"}, load_data, exp_load);
      end else begin
         if (rd && ok) exp_q.push_back(model_load(f3, addr, rdata));
         for (int n = 1; n <= TMO; n++) begin
            check({tag, " req"}, 32'(dmem.req), 32'd1);
            check({tag, " addr"}, dmem.addr, {addr[31:2], 2'b00});
            check({tag, " we"}, 32'(dmem.we), 32'(!rd));
            check({tag, " be"}, 32'(dmem.be), 32'(model_be(rd, f3, addr)));
            if (!rd) check({tag, " wdata"}, dmem.wdata, model_wdata(f3, rs2));
            check({tag, " early_done"}, 32'(done), 32'd0);
            if (n == 1) begin
               start = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
               funct3 = F3_W; alu_result = 32'h0000_0F00;
            end
            if (n == ack_at) begin
               dmem.ack = 1'b1; dmem.rdata = rdata;
            end
            tick();
            start = 1'b0; dmem.ack = 1'b0; dmem.rdata = $urandom();
            if (n == ack_at) break;
         end
         if (exp_q.size() != 0) exp_load = exp_q.pop_front();
         check({tag, " done"}, 32'(done), 32'd1);
         check({tag, " err_bus"}, 32'(err_bus), 32'(!ok));
         check({tag, " err_other"}, 32'({err_illegal, err_misaligned}), 32'd0);
         check({tag, " req_low"}, 32'(dmem.req), 32'd0);
         check({tag, " load_data"}, load_data, exp_load);
      end
      tick();
      check({tag, " idle_busy"}, 32'(busy), 32'd0);
      check({tag, " idle_done"}, 32'(done), 32'd0);
   endtask

   initial begin
      dmem.ack = 1'b0;
      dmem.rdata = '0;
      tick();
      tick();
      check("rst busy", 32'(busy), 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst req", 32'(dmem.req), 32'd0);
      check("rst load", load_data, 32'd0);
      check("rst errs", 32'({err_misaligned, err_illegal, err_bus}), 32'd0);
      check("rst state", 32'(state_dbg), 32'(IDLE));
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      run_op(1'b0, F3_W, 32'h100, 32'hDEADBEEF, 3, '0, "sw");
      run_op(1'b1, F3_B, 32'h203, 32'h0, 1, 32'h80FF_0000, "lb");
      run_op(1'b1, F3_BU, 32'h203, 32'h0, 2, 32'h80FF_0000, "lbu");
      run_op(1'b1, F3_HU, 32'h202, 32'h0, 1, 32'h80FF_0000, "lhu");
      run_op(1'b1, F3_H, 32'h202, 32'h0, 1, 32'h80FF_0000, "lh");
      run_op(1'b0, F3_H, 32'h102, 32'h1234ABCD, 2, '0, "sh");
      run_op(1'b0, F3_B, 32'h101, 32'h1234ABCD, 1, '0, "sb");
      run_op(1'b1, F3_W, 32'h102, 32'h0, 1, '0, "lw_mis");
      run_op(1'b0, 3'b100, 32'h100, 32'h0, 1, '0, "st_ill");
      run_op(1'b1, 3'b011, 32'h101, 32'h0, 1, '0, "ld_ill_prio");
      run_op(1'b1, F3_W, 32'h400, 32'h0, 0, 32'h5555_AAAA, "lw_tmo");

      // Late ack in IDLE must not complete anything.
      dmem.ack = 1'b1; dmem.rdata = 32'h1357_9BDF;
      tick();
      dmem.ack = 1'b0;
      check("late_ack done", 32'(done), 32'd0);
      check("late_ack busy", 32'(busy), 32'd0);
      tick();
      check("late_ack load", load_data, exp_load);

      run_op(1'b1, F3_W, 32'h404, 32'h0, TMO, 32'hCAFE_F00D, "ack_at_expiry");

      start = 1'b1; mem_read = 1'b1; mem_write = 1'b1; funct3 = F3_W; alu_result = 32'h500;
      tick();
      start = 1'b0;
      check("both busy", 32'(busy), 32'd0);
      tick();
      check("both done", 32'(done), 32'd0);
      start = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
      tick();
      start = 1'b0;
      check("neither busy", 32'(busy), 32'd0);
      check("neither req", 32'(dmem.req), 32'd0);

      // Asynchronous reset in the middle of a request.
      start = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = F3_W; alu_result = 32'h300;
      tick();
      start = 1'b0;
      check("pre_rst req", 32'(dmem.req), 32'd1);
      tick();
      rst_n = 1'b0;
      #1;
      exp_load = '0;
      check("async_rst req", 32'(dmem.req), 32'd0);
      check("async_rst busy", 32'(busy), 32'd0);
      check("async_rst load", load_data, exp_load);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      dmem.ack = 1'b1; dmem.rdata = 32'hFFFF_FFFF;
      tick();
      dmem.ack = 1'b0;
      check("post_rst done", 32'(done), 32'd0);
      tick();
      check("post_rst done2", 32'(done), 32'd0);
      check("post_rst load", load_data, exp_load);
      run_op(1'b1, F3_H, 32'h306, 32'h0, 2, 32'h7FFF_1234, "after_rst");

      for (int i = 0; i < 40; i++) begin
         bit rd;
         logic [2:0] f3;
         rd = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) != 0) begin
            case ($urandom_range(0, rd ? 4 : 2))
               0: f3 = F3_B;
               1: f3 = F3_H;
               2: f3 = F3_W;
               3: f3 = F3_BU;
               default: f3 = F3_HU;
            endcase
         end else begin
            f3 = 3'($urandom_range(0, 7));
         end
         run_op(rd, f3, 32'h1000 + $urandom_range(0, 255), $urandom(),
                int'($urandom_range(0, TMO + 1)), $urandom(), "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
